// File: rtl/hdmi_tmds_pkg.sv
// TMDS control tokens, video guard-band words and the period_state encoding
// shared by the period scheduler and its environment.
package hdmi_tmds_pkg;

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  localparam logic [9:0] GB_CH0 = 10'b1011001100;
  localparam logic [9:0] GB_CH1 = 10'b0100110011;
  localparam logic [9:0] GB_CH2 = 10'b1011001100;

  typedef enum logic [1:0] {
    PS_CTRL  = 2'd0,
    PS_PRE   = 2'd1,
    PS_GUARD = 2'd2,
    PS_VIDEO = 2'd3
  } period_e;

  // Control token selected by the two control bits {c1,c0}.
  function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
    case ({c1, c0})
      2'b00:   return TOK_00;
      2'b01:   return TOK_01;
      2'b10:   return TOK_10;
      default: return TOK_11;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_period_sched_if.sv
// Pixel-side bundle of the period scheduler: encoded pixel stream and sync in,
// serializer words, period state and error flag out.
interface hdmi_period_sched_if;

  logic       de_in;
  logic       hsync_in;
  logic       vsync_in;
  logic [9:0] tmds_in_ch0;
  logic [9:0] tmds_in_ch1;
  logic [9:0] tmds_in_ch2;
  logic       err_clr;
  logic [9:0] par_data_ch0;
  logic [9:0] par_data_ch1;
  logic [9:0] par_data_ch2;
  logic [1:0] period_state;
  logic       err_short_blank;

  modport master (
    output de_in, hsync_in, vsync_in, tmds_in_ch0, tmds_in_ch1, tmds_in_ch2, err_clr,
    input  par_data_ch0, par_data_ch1, par_data_ch2, period_state, err_short_blank
  );

  modport slave (
    input  de_in, hsync_in, vsync_in, tmds_in_ch0, tmds_in_ch1, tmds_in_ch2, err_clr,
    output par_data_ch0, par_data_ch1, par_data_ch2, period_state, err_short_blank
  );

endinterface

// File: rtl/tmds_delay_line.sv
// Fixed-depth synchronous shift register; every stage is cleared by sys_rst.
module tmds_delay_line #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 33
) (
  input  logic             clk_1x,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  // Advance one stage per pixel clock; reset flushes the whole line.
  always_ff @(posedge clk_1x) begin
    if (sys_rst) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/hdmi_period_sched.sv
// Per-pixel period scheduler ahead of the three TMDS serializers.
// The pixel stream is delayed PRE_LEN+GB_LEN cycles so that a de rise seen on
// the undelayed input can open preamble and guard band before the first pixel
// leaves the delay line. Outputs are registered: total latency DLY+1.
// Build option HDMI_GUARD_EN: defined -> HDMI framing (preamble, guard band,
// short-blank detection); undefined -> DVI mode (control tokens or video only).
module hdmi_period_sched
  import hdmi_tmds_pkg::*;
#(
  parameter int PRE_LEN = 8,
  parameter int GB_LEN  = 2
) (
  input logic                clk_1x,
  input logic                sys_rst,
  hdmi_period_sched_if.slave bus
);

  localparam int DLY   = PRE_LEN + GB_LEN;
  localparam int CNT_W = $clog2(DLY + 1);

  logic [32:0] dl_in;
  logic [32:0] dl_out;
  logic        de_d;
  logic        hs_d;
  logic        vs_d;
  logic [29:0] vid_d;

  period_e     state_p1;
  logic [29:0] par_p1;

  // Channel words for the period about to be presented ({ch2,ch1,ch0}).
  function automatic logic [29:0] period_words(input period_e s, input logic vs,
                                               input logic hs, input logic [29:0] vid);
    case (s)
      PS_PRE:   return {TOK_00, TOK_01, ctrl_token(vs, hs)};
      PS_GUARD: return {GB_CH2, GB_CH1, GB_CH0};
      PS_VIDEO: return vid;
      default:  return {TOK_00, TOK_00, ctrl_token(vs, hs)};
    endcase
  endfunction

  assign dl_in = {bus.de_in, bus.hsync_in, bus.vsync_in,
                  bus.tmds_in_ch2, bus.tmds_in_ch1, bus.tmds_in_ch0};

  tmds_delay_line #(.DEPTH(DLY), .WIDTH(33)) u_dly (
    .clk_1x  (clk_1x),
    .sys_rst (sys_rst),
    .din     (dl_in),
    .dout    (dl_out)
  );

  assign de_d  = dl_out[32];
  assign hs_d  = dl_out[31];
  assign vs_d  = dl_out[30];
  assign vid_d = dl_out[29:0];

  assign bus.par_data_ch0 = par_p1[9:0];
  assign bus.par_data_ch1 = par_p1[19:10];
  assign bus.par_data_ch2 = par_p1[29:20];
  assign bus.period_state = state_p1;

`ifdef HDMI_GUARD_EN

  logic             de_in_q;
  logic             rise;
  logic             skip_d;
  logic             direct_vid;
  logic             reject;
  logic             err_q;
  logic [CNT_W-1:0] cnt;

  // A rise is honoured only from CTRL; a rejected rise marks its region so the
  // region is later sent as bare video, entered straight from CTRL.
  assign rise       = bus.de_in & ~de_in_q;
  assign direct_vid = (state_p1 == PS_CTRL) & skip_d & de_d;
  assign reject     = rise & ((state_p1 != PS_CTRL) | direct_vid);

  tmds_delay_line #(.DEPTH(DLY), .WIDTH(1)) u_skip (
    .clk_1x  (clk_1x),
    .sys_rst (sys_rst),
    .din     (reject),
    .dout    (skip_d)
  );

  assign bus.err_short_blank = err_q;

  // Period FSM: state, counter, registered channel words and sticky error.
  always_ff @(posedge clk_1x) begin
    if (sys_rst) begin
      state_p1 <= PS_CTRL;
      cnt      <= '0;
      de_in_q  <= 1'b0;
      err_q    <= 1'b0;
      par_p1   <= {TOK_00, TOK_00, TOK_00};
    end else begin
      de_in_q <= bus.de_in;
      if (reject)           err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
      cnt <= '0;
      unique case (state_p1)
        PS_CTRL: begin
          if (direct_vid) begin
            state_p1 <= PS_VIDEO;
            par_p1   <= period_words(PS_VIDEO, vs_d, hs_d, vid_d);
          end else if (rise) begin
            state_p1 <= PS_PRE;
            par_p1   <= period_words(PS_PRE, vs_d, hs_d, vid_d);
          end else begin
            par_p1   <= period_words(PS_CTRL, vs_d, hs_d, vid_d);
          end
        end
        PS_PRE: begin
          if (cnt == CNT_W'(PRE_LEN - 1)) begin
            state_p1 <= PS_GUARD;
            par_p1   <= period_words(PS_GUARD, vs_d, hs_d, vid_d);
          end else begin
            cnt      <= cnt + CNT_W'(1);
            par_p1   <= period_words(PS_PRE, vs_d, hs_d, vid_d);
          end
        end
        PS_GUARD: begin
          if (cnt == CNT_W'(GB_LEN - 1)) begin
            state_p1 <= PS_VIDEO;
            par_p1   <= period_words(PS_VIDEO, vs_d, hs_d, vid_d);
          end else begin
            cnt      <= cnt + CNT_W'(1);
            par_p1   <= period_words(PS_GUARD, vs_d, hs_d, vid_d);
          end
        end
        PS_VIDEO: begin
          if (de_d) begin
            par_p1   <= period_words(PS_VIDEO, vs_d, hs_d, vid_d);
          end else begin
            state_p1 <= PS_CTRL;
            par_p1   <= period_words(PS_CTRL, vs_d, hs_d, vid_d);
          end
        end
      endcase
    end
  end

`else

  logic unused_err_clr;

  assign unused_err_clr      = bus.err_clr;
  assign bus.err_short_blank = 1'b0;

  // DVI: present video whenever delayed de is high, control tokens otherwise.
  always_ff @(posedge clk_1x) begin
    if (sys_rst) begin
      state_p1 <= PS_CTRL;
      par_p1   <= {TOK_00, TOK_00, TOK_00};
    end else if (de_d) begin
      state_p1 <= PS_VIDEO;
      par_p1   <= period_words(PS_VIDEO, vs_d, hs_d, vid_d);
    end else begin
      state_p1 <= PS_CTRL;
      par_p1   <= period_words(PS_CTRL, vs_d, hs_d, vid_d);
    end
  end

`endif

endmodule

// File: tb/tb_hdmi_period_sched.sv
// Directed bench for hdmi_period_sched (PRE_LEN=8, GB_LEN=2, latency 11).
// Expectations follow HDMI framing when HDMI_GUARD_EN is defined, DVI otherwise.
`timescale 1ns/1ps
module tb_hdmi_period_sched;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] G0  = 10'b1011001100;
  localparam logic [9:0] G1  = 10'b0100110011;
  localparam logic [9:0] G2  = 10'b1011001100;
  localparam int         LAT = 11;
  localparam int         NCYC = 1024;

  logic clk_1x  = 1'b0;
  logic sys_rst = 1'b1;

  hdmi_period_sched_if bus();

  hdmi_period_sched #(.PRE_LEN(8), .GB_LEN(2)) dut (
    .clk_1x  (clk_1x),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 clk_1x = ~clk_1x;

  logic [9:0] h_c0 [NCYC];
  logic [9:0] h_c1 [NCYC];
  logic [9:0] h_c2 [NCYC];
  logic [1:0] o_st [NCYC];
  logic [9:0] o_c0 [NCYC];
  logic [9:0] o_c1 [NCYC];
  logic [9:0] o_c2 [NCYC];
  logic       o_err [NCYC];

  int cyc   = 0;
  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pixel cycle: drive inputs after the edge, record them, sample outputs mid-cycle.
  task automatic tick(input logic r, input logic de, input logic hs, input logic vs,
                      input logic clr);
    @(posedge clk_1x);
    #1;
    sys_rst         = r;
    bus.de_in       = de;
    bus.hsync_in    = hs;
    bus.vsync_in    = vs;
    bus.err_clr     = clr;
    bus.tmds_in_ch0 = 10'($urandom_range(0, 1023));
    bus.tmds_in_ch1 = 10'($urandom_range(0, 1023));
    bus.tmds_in_ch2 = 10'($urandom_range(0, 1023));
    h_c0[cyc] = bus.tmds_in_ch0;
    h_c1[cyc] = bus.tmds_in_ch1;
    h_c2[cyc] = bus.tmds_in_ch2;
    @(negedge clk_1x);
    o_st[cyc]  = bus.period_state;
    o_c0[cyc]  = bus.par_data_ch0;
    o_c1[cyc]  = bus.par_data_ch1;
    o_c2[cyc]  = bus.par_data_ch2;
    o_err[cyc] = bus.err_short_blank;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic de_high(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_out(input string tag, input int t, input logic [1:0] st,
                           input logic [9:0] c0, input logic [9:0] c1, input logic [9:0] c2);
    check_val($sformatf("%s@%0d state", tag, t), 32'(o_st[t]), 32'(st));
    check_val($sformatf("%s@%0d ch0", tag, t), 32'(o_c0[t]), 32'(c0));
    check_val($sformatf("%s@%0d ch1", tag, t), 32'(o_c1[t]), 32'(c1));
    check_val($sformatf("%s@%0d ch2", tag, t), 32'(o_c2[t]), 32'(c2));
  endtask

  task automatic check_video(input string tag, input int t);
    check_out(tag, t, 2'd3, h_c0[t-LAT], h_c1[t-LAT], h_c2[t-LAT]);
  endtask

  // Output cycles n+1..n+upto after an accepted rise at n (hs=vs=0).
  task automatic check_prefix(input string tag, input int n, input int upto);
    for (int k = 1; k <= upto; k++) begin
`ifdef HDMI_GUARD_EN
      if (k <= 8) check_out(tag, n + k, 2'd1, T00, T01, T00);
      else        check_out(tag, n + k, 2'd2, G0, G1, G2);
`else
      check_out(tag, n + k, 2'd0, T00, T00, T00);
`endif
    end
  endtask

  // Whole framed line: de high for len cycles starting at input cycle n.
  task automatic check_line(input string tag, input int n, input int len);
    check_out(tag, n, 2'd0, T00, T00, T00);
    check_prefix(tag, n, 10);
    for (int k = 11; k <= 10 + len; k++) check_video(tag, n + k);
    check_out(tag, n + 11 + len, 2'd0, T00, T00, T00);
  endtask

  int n2, s1, s2, s3, n4, n5, n6, n7, c4;

  initial begin
    bus.de_in       = 1'b0;
    bus.hsync_in    = 1'b0;
    bus.vsync_in    = 1'b0;
    bus.err_clr     = 1'b0;
    bus.tmds_in_ch0 = '0;
    bus.tmds_in_ch1 = '0;
    bus.tmds_in_ch2 = '0;

    // Reset held three cycles, then a blank interval
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(12);
    check_out("rst", 1, 2'd0, T00, T00, T00);
    check_out("rst", 3, 2'd0, T00, T00, T00);
    check_val("rst err", 32'(o_err[3]), 32'd0);
    check_out("blank", 14, 2'd0, T00, T00, T00);

    // Normal line, de high 16 cycles
    n2 = cyc;
    de_high(16);
    idle(15);
    check_line("line", n2, 16);

    // Sync tokens on ch0 with 11-cycle latency
    s1 = cyc;
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    s2 = cyc;
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    s3 = cyc;
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(12);
    check_out("hs", s1 + 10, 2'd0, T00, T00, T00);
    check_out("hs", s1 + 11, 2'd0, T01, T00, T00);
    check_out("hsvs", s2 + 10, 2'd0, T01, T00, T00);
    check_out("hsvs", s2 + 11, 2'd0, T11, T00, T00);
    check_out("vs", s3 + 10, 2'd0, T11, T00, T00);
    check_out("vs", s3 + 11, 2'd0, T10, T00, T00);

    // Single-cycle active region
    n5 = cyc;
    de_high(1);
    idle(14);
    check_line("de1", n5, 1);

    // Short blank: 20 high, 5 low, 20 high; err_clr coincides with the rejected rise
    n4 = cyc;
    de_high(20);
    idle(5);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    de_high(19);
    idle(20);
    check_line("short", n4, 20);
    for (int k = 32; k <= 35; k++) check_out("short gap", n4 + k, 2'd0, T00, T00, T00);
    for (int k = 36; k <= 55; k++) check_video("short vid", n4 + k);
    check_out("short end", n4 + 56, 2'd0, T00, T00, T00);
    check_val("err before", 32'(o_err[n4 + 25]), 32'd0);
`ifdef HDMI_GUARD_EN
    check_val("err set", 32'(o_err[n4 + 26]), 32'd1);
    check_val("err sticky", 32'(o_err[n4 + 64]), 32'd1);
`else
    check_val("err set", 32'(o_err[n4 + 26]), 32'd0);
    check_val("err sticky", 32'(o_err[n4 + 64]), 32'd0);
`endif
    c4 = cyc;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(12);
    check_val("err clr", 32'(o_err[c4 + 1]), 32'd0);

    // Reset asserted while the output is in the guard band
    n6 = cyc;
    de_high(9);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(14);
    check_prefix("rstmid", n6, 9);
    check_out("rstmid", n6 + 10, 2'd0, T00, T00, T00);
    check_val("rstmid err", 32'(o_err[n6 + 10]), 32'd0);
    for (int k = 11; k <= 22; k++) check_out("rstmid flush", n6 + k, 2'd0, T00, T00, T00);

    n7 = cyc;
    de_high(16);
    idle(15);
    check_line("after rst", n7, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
